// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding,
// requester IDs and default bus widths.
package ram_arbiter_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: chooses which of two requesters wins an arbitration round.
// With RAM_ARBITER_ROUND_ROBIN_EN defined, a contention goes to the requester
// that was not granted last and the pointer moves only when a grant is made.
// Without it, A always beats B and there is no pointer state at all.
module rr_pick
    import ram_arbiter_pkg::*;
(
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    input  logic Clock,
    input  logic Reset,
    input  logic update,
`endif
    input  logic a_req,
    input  logic b_req,
    output logic winner,
    output logic any_req
);

    assign any_req = a_req || b_req;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic last_id;

    // Remember who was granted last; reset value makes A the first choice.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_id <= ID_B;
        end else if (update) begin
            last_id <= winner;
        end
    end

    // On contention the requester not granted last wins.
    always_comb begin
        winner = ID_A;
        if (a_req && b_req) begin
            winner = (last_id == ID_A) ? ID_B : ID_A;
        end else if (b_req) begin
            winner = ID_B;
        end
    end
`else
    assign winner = (a_req || !b_req) ? ID_A : ID_B;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one external RAM port between requesters A and B.
// Two-state FSM (IDLE -> ISSUE -> IDLE) issues at most one access every two
// cycles; all outputs are registered. Read responses are routed back through
// a two-stage tag pipeline so overlapping reads return in order.
// Optional macro RAM_ARBITER_ROUND_ROBIN_EN selects round-robin instead of
// fixed A-first priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     AReq_i,
    input  logic                     AWrite_i,
    input  logic [ADDRESS_WIDTH-1:0] AAddress_i,
    input  logic [DATA_WIDTH-1:0]    AData_i,
    input  logic                     BReq_i,
    input  logic                     BWrite_i,
    input  logic [ADDRESS_WIDTH-1:0] BAddress_i,
    input  logic [DATA_WIDTH-1:0]    BData_i,
    output logic                     AGrant_o,
    output logic                     BGrant_o,
    output logic                     AValid_o,
    output logic                     BValid_o,
    output logic [DATA_WIDTH-1:0]    AData_o,
    output logic [DATA_WIDTH-1:0]    BData_o,
    output logic                     RamReadEnable_o,
    output logic                     RamWriteEnable_o,
    output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
    output logic [DATA_WIDTH-1:0]    RamData_o,
    input  logic [DATA_WIDTH-1:0]    RamData_i
);

    state_t                   state, next_state;
    logic                     any_req, winner;
    logic                     a_grant_next, b_grant_next;
    logic                     rd_en_next, wr_en_next;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0]    wdata_next;
    logic                     tag0_valid, tag0_id, tag0_valid_next, tag0_id_next;
    logic                     tag1_valid, tag1_id;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic pick_update;
    assign pick_update = (state == IDLE) && any_req;
`endif

    rr_pick u_pick (
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        .Clock   (Clock),
        .Reset   (Reset),
        .update  (pick_update),
`endif
        .a_req   (AReq_i),
        .b_req   (BReq_i),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next state and next command: latch the winner in IDLE, release in ISSUE.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        next_state      = state;
        a_grant_next    = 1'b0;
        b_grant_next    = 1'b0;
        rd_en_next      = 1'b0;
        wr_en_next      = 1'b0;
        addr_next       = RamAddress_o;
        wdata_next      = RamData_o;
        tag0_valid_next = 1'b0;
        tag0_id_next    = tag0_id;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state   = ISSUE;
                    tag0_id_next = winner;
                    if (winner == ID_A) begin
                        a_grant_next = 1'b1;
                        wr_en_next   = AWrite_i;
                        addr_next    = AAddress_i;
                        wdata_next   = AData_i;
                    end else begin
                        b_grant_next = 1'b1;
                        wr_en_next   = BWrite_i;
                        addr_next    = BAddress_i;
                        wdata_next   = BData_i;
                    end
                    rd_en_next      = !wr_en_next;
                    tag0_valid_next = !wr_en_next;
                end
            end
            ISSUE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, grant and RAM command registers.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state            <= IDLE;
            AGrant_o         <= 1'b0;
            BGrant_o         <= 1'b0;
            RamReadEnable_o  <= 1'b0;
            RamWriteEnable_o <= 1'b0;
            RamAddress_o     <= '0;
            RamData_o        <= '0;
            tag0_valid       <= 1'b0;
            tag0_id          <= ID_A;
        end else begin
            state            <= next_state;
            AGrant_o         <= a_grant_next;
            BGrant_o         <= b_grant_next;
            RamReadEnable_o  <= rd_en_next;
            RamWriteEnable_o <= wr_en_next;
            RamAddress_o     <= addr_next;
            RamData_o        <= wdata_next;
            tag0_valid       <= tag0_valid_next;
            tag0_id          <= tag0_id_next;
        end
    end

    // Second tag stage lines up with RAM data; it steers the read response.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tag1_valid <= 1'b0;
            tag1_id    <= ID_A;
            AValid_o   <= 1'b0;
            BValid_o   <= 1'b0;
            AData_o    <= '0;
            BData_o    <= '0;
        end else begin
            tag1_valid <= tag0_valid;
            tag1_id    <= tag0_id;
            AValid_o   <= tag1_valid && (tag1_id == ID_A);
            BValid_o   <= tag1_valid && (tag1_id == ID_B);
            if (tag1_valid && (tag1_id == ID_A)) AData_o <= RamData_i;
            if (tag1_valid && (tag1_id == ID_B)) BData_o <= RamData_i;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter. Stimulus pushes hand-computed grant and
// read-response expectations into queues; a monitor on the falling edge pops
// and compares whenever the DUT shows a grant/RAM command or a valid.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        AReq_i, AWrite_i, BReq_i, BWrite_i;
    logic [15:0] AAddress_i, BAddress_i;
    logic [7:0]  AData_i, BData_i;
    logic        AGrant_o, BGrant_o, AValid_o, BValid_o;
    logic [7:0]  AData_o, BData_o;
    logic        RamReadEnable_o, RamWriteEnable_o;
    logic [15:0] RamAddress_o;
    logic [7:0]  RamData_o;
    logic [7:0]  RamData_i;

    typedef struct {
        int          cyc;
        logic        id;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } grant_exp_t;

    typedef struct {
        int         cyc;
        logic       id;
        logic [7:0] data;
    } resp_exp_t;

    grant_exp_t grant_q[$];
    resp_exp_t  resp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    logic [7:0] mem [0:65535];

    ram_arbiter dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .AReq_i           (AReq_i),
        .AWrite_i         (AWrite_i),
        .AAddress_i       (AAddress_i),
        .AData_i          (AData_i),
        .BReq_i           (BReq_i),
        .BWrite_i         (BWrite_i),
        .BAddress_i       (BAddress_i),
        .BData_i          (BData_i),
        .AGrant_o         (AGrant_o),
        .BGrant_o         (BGrant_o),
        .AValid_o         (AValid_o),
        .BValid_o         (BValid_o),
        .AData_o          (AData_o),
        .BData_o          (BData_o),
        .RamReadEnable_o  (RamReadEnable_o),
        .RamWriteEnable_o (RamWriteEnable_o),
        .RamAddress_o     (RamAddress_o),
        .RamData_o        (RamData_o),
        .RamData_i        (RamData_i)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // External RAM model: registered read, data valid the cycle after enable.
    always @(posedge Clock) begin
        if (RamWriteEnable_o) mem[RamAddress_o] <= RamData_o;
        if (RamReadEnable_o)  RamData_i <= mem[RamAddress_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic wr, input logic [15:0] addr, input logic [7:0] data);
        AReq_i = req; AWrite_i = wr; AAddress_i = addr; AData_i = data;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [15:0] addr, input logic [7:0] data);
        BReq_i = req; BWrite_i = wr; BAddress_i = addr; BData_i = data;
    endtask

    task automatic exp_grant(input int c, input logic id, input logic wr, input logic [15:0] addr, input logic [7:0] data);
        grant_exp_t e;
        e.cyc = c; e.id = id; e.wr = wr; e.addr = addr; e.data = data;
        grant_q.push_back(e);
    endtask

    task automatic exp_resp(input int c, input logic id, input logic [7:0] data);
        resp_exp_t e;
        e.cyc = c; e.id = id; e.data = data;
        resp_q.push_back(e);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_grants"}, {30'd0, AGrant_o, BGrant_o}, 32'd0);
        check({tag, "_valids"}, {30'd0, AValid_o, BValid_o}, 32'd0);
        check({tag, "_ram_en"}, {30'd0, RamReadEnable_o, RamWriteEnable_o}, 32'd0);
        check({tag, "_ram_addr"}, {16'd0, RamAddress_o}, 32'd0);
        check({tag, "_ram_wdata"}, {24'd0, RamData_o}, 32'd0);
        check({tag, "_a_data"}, {24'd0, AData_o}, 32'd0);
        check({tag, "_b_data"}, {24'd0, BData_o}, 32'd0);
    endtask

    // Monitor: compare every grant/command and every read response.
    always @(negedge Clock) begin
        grant_exp_t g;
        resp_exp_t  r;
        if (Reset) begin
            last_a = 8'h00;
            last_b = 8'h00;
        end else begin
            if (AGrant_o || BGrant_o) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", {30'd0, AGrant_o, BGrant_o}, 32'd0);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_cycle", g.cyc, cyc);
                    check("grant_id", {30'd0, AGrant_o, BGrant_o}, (g.id == ID_A) ? 32'd2 : 32'd1);
                    check("ram_en", {30'd0, RamReadEnable_o, RamWriteEnable_o}, g.wr ? 32'd1 : 32'd2);
                    check("ram_addr", {16'd0, RamAddress_o}, {16'd0, g.addr});
                    if (g.wr) check("ram_wdata", {24'd0, RamData_o}, {24'd0, g.data});
                end
            end else if (RamReadEnable_o || RamWriteEnable_o) begin
                check("ram_en_without_grant", {30'd0, RamReadEnable_o, RamWriteEnable_o}, 32'd0);
            end
            if (AValid_o || BValid_o) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_valid", {30'd0, AValid_o, BValid_o}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("valid_cycle", r.cyc, cyc);
                    check("valid_id", {30'd0, AValid_o, BValid_o}, (r.id == ID_A) ? 32'd2 : 32'd1);
                    if (r.id == ID_A) begin
                        check("a_rdata", {24'd0, AData_o}, {24'd0, r.data});
                        check("b_data_hold", {24'd0, BData_o}, {24'd0, last_b});
                        last_a = r.data;
                    end else begin
                        check("b_rdata", {24'd0, BData_o}, {24'd0, r.data});
                        check("a_data_hold", {24'd0, AData_o}, {24'd0, last_a});
                        last_b = r.data;
                    end
                end
            end
        end
    end

    initial begin
        int c;
        Reset = 1'b1;
        set_a(0, 0, 16'h0, 8'h0);
        set_b(0, 0, 16'h0, 8'h0);
        repeat (3) @(negedge Clock);
        reset_checks("reset");
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // A writes 0x1234 <- 0x5A: grant next cycle, no response.
        c = cyc;
        set_a(1, 1, 16'h1234, 8'h5A);
        exp_grant(c + 1, ID_A, 1, 16'h1234, 8'h5A);
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        repeat (4) @(negedge Clock);

        // B reads 0x1234: grant at +1, BValid with 0x5A at +3.
        c = cyc;
        set_b(1, 0, 16'h1234, 8'h00);
        exp_grant(c + 1, ID_B, 0, 16'h1234, 8'h00);
        exp_resp(c + 3, ID_B, 8'h5A);
        @(negedge Clock); set_b(0, 0, 16'h0, 8'h0);
        repeat (5) @(negedge Clock);

        // Contending writes, then contending reads that overlap in flight.
        c = cyc;
        set_a(1, 1, 16'h0100, 8'hA1);
        set_b(1, 1, 16'h0200, 8'hB2);
        exp_grant(c + 1, ID_A, 1, 16'h0100, 8'hA1);
        exp_grant(c + 3, ID_B, 1, 16'h0200, 8'hB2);
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        @(negedge Clock);
        @(negedge Clock); set_b(0, 0, 16'h0, 8'h0);
        @(negedge Clock);
        c = cyc;
        set_a(1, 0, 16'h0200, 8'h00);
        set_b(1, 0, 16'h0100, 8'h00);
        exp_grant(c + 1, ID_A, 0, 16'h0200, 8'h00);
        exp_grant(c + 3, ID_B, 0, 16'h0100, 8'h00);
        exp_resp(c + 3, ID_A, 8'hB2);
        exp_resp(c + 5, ID_B, 8'hA1);
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        @(negedge Clock);
        @(negedge Clock); set_b(0, 0, 16'h0, 8'h0);
        repeat (5) @(negedge Clock);

        // A re-requests right after its grant while B keeps waiting.
        c = cyc;
        set_a(1, 0, 16'h0100, 8'h00);
        set_b(1, 0, 16'h0200, 8'h00);
        exp_grant(c + 1, ID_A, 0, 16'h0100, 8'h00);
        exp_resp(c + 3, ID_A, 8'hA1);
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        exp_grant(c + 3, ID_B, 0, 16'h0200, 8'h00);
        exp_grant(c + 5, ID_A, 0, 16'h1234, 8'h00);
        exp_resp(c + 5, ID_B, 8'hB2);
        exp_resp(c + 7, ID_A, 8'h5A);
`else
        exp_grant(c + 3, ID_A, 0, 16'h1234, 8'h00);
        exp_grant(c + 5, ID_B, 0, 16'h0200, 8'h00);
        exp_resp(c + 5, ID_A, 8'h5A);
        exp_resp(c + 7, ID_B, 8'hB2);
`endif
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        @(negedge Clock); set_a(1, 0, 16'h1234, 8'h00);
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        @(negedge Clock); set_b(0, 0, 16'h0, 8'h0);
        @(negedge Clock);
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
`else
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        @(negedge Clock);
        @(negedge Clock); set_b(0, 0, 16'h0, 8'h0);
`endif
        repeat (6) @(negedge Clock);

        // Reset the cycle after a read grant: the read is dropped, A wins next.
        c = cyc;
        set_a(1, 0, 16'h0100, 8'h00);
        exp_grant(c + 1, ID_A, 0, 16'h0100, 8'h00);
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        @(negedge Clock); Reset = 1'b1;
        @(negedge Clock); reset_checks("mid_reset");
        @(negedge Clock);
        Reset = 1'b0;
        c = cyc;
        set_a(1, 0, 16'h0200, 8'h00);
        set_b(1, 0, 16'h0100, 8'h00);
        exp_grant(c + 1, ID_A, 0, 16'h0200, 8'h00);
        exp_grant(c + 3, ID_B, 0, 16'h0100, 8'h00);
        exp_resp(c + 3, ID_A, 8'hB2);
        exp_resp(c + 5, ID_B, 8'hA1);
        @(negedge Clock); set_a(0, 0, 16'h0, 8'h0);
        @(negedge Clock);
        @(negedge Clock); set_b(0, 0, 16'h0, 8'h0);

        // Bounded drain: anything left in the queues never showed up.
        for (int i = 0; i < 40 && (grant_q.size() != 0 || resp_q.size() != 0); i++)
            @(negedge Clock);
        repeat (4) @(negedge Clock);
        check("pending_grants", grant_q.size(), 32'd0);
        check("pending_responses", resp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
